// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding
// and the legal operand width range.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam int unsigned MIN_WIDTH = 2;
    localparam int unsigned MAX_WIDTH = 32;

    function automatic bit width_ok(input int unsigned w);
        return (w >= MIN_WIDTH) && (w <= MAX_WIDTH);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder: two half-adder stages whose carries are ORed.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    always_comb begin
        ha0_s = a ^ b;
        ha0_c = a & b;
        s     = ha0_s ^ cin;
        ha1_c = ha0_s & cin;
        co    = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: latches operands on start, resolves one bit
// per clock LSB-first through a single full adder, then pulses done.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder: WIDTH must be within 2..32");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cmsb_q, cmsb_d;
    logic             sub_q, sub_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .co  (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cmsb_d  = cmsb_q;
        sub_d   = sub_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    // Subtraction is a + ~b + ~cin, so borrow-in inverts into the carry.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ^ cin;
                    sub_d   = sub;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_co;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 2)) begin
                    cmsb_d = fa_co;
                end
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cout_d  = sub_q ^ fa_co;
                    ovf_d   = cmsb_q ^ fa_co;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cmsb_q  <= 1'b0;
            sub_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cmsb_q  <= cmsb_d;
            sub_q   <= sub_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=16: directed
// vectors, randomized operations against an arithmetic model, reset abort.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, sub8, cin8;
    logic [7:0]  a8, b8;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;
    logic        start16, sub16, cin16;
    logic [15:0] a16, b16;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .sub(sub16), .cin(cin16),
        .a(a16), .b(b16), .busy(busy16), .done(done16), .sum(sum16),
        .cout(cout16), .ovf(ovf16)
    );

    typedef struct {
        bit          wide;
        bit          sub;
        bit          cin;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        bit          cout;
        bit          ovf;
        int          inject;
        string       name;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input bit w, input bit s, input bit c, input logic [31:0] av,
                           input logic [31:0] bv, input logic [31:0] sm, input bit co,
                           input bit ov, input int inj, input string nm);
        vec_t v;
        v.wide = w; v.sub = s; v.cin = c; v.a = av; v.b = bv;
        v.sum = sm; v.cout = co; v.ovf = ov; v.inject = inj; v.name = nm;
        tbl.push_back(v);
    endtask

    // Reference: plain signed/unsigned integer arithmetic modulo 2^w.
    function automatic void model(input int unsigned w, input bit s, input bit c,
                                  input logic [31:0] av, input logic [31:0] bv,
                                  output logic [31:0] sm, output bit co, output bit ov);
        longint m  = longint'(1) << w;
        longint ua = longint'(av) & (m - 1);
        longint ub = longint'(bv) & (m - 1);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint full;
        longint sres;
        full = s ? (ua - ub - longint'(c)) : (ua + ub + longint'(c));
        sres = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
        sm   = 32'(full & (m - 1));
        co   = s ? (ua < ub + longint'(c)) : (full >= m);
        ov   = (sres < -(m / 2)) || (sres >= m / 2);
    endfunction

    task automatic drive(input bit wide, input bit st, input bit s, input bit c,
                         input logic [31:0] av, input logic [31:0] bv);
        if (wide) begin
            start16 = st; sub16 = s; cin16 = c; a16 = av[15:0]; b16 = bv[15:0];
        end else begin
            start8 = st; sub8 = s; cin8 = c; a8 = av[7:0]; b8 = bv[7:0];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // IDLE cycle after done so consecutive calls run back-to-back.
    task automatic do_op(input bit wide, input bit s, input bit c, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] es, input bit ec,
                         input bit eo, input int inject, input string nm, output time t_done);
        int          w = wide ? 16 : 8;
        int          busy_n = 0, done_n = 0, done_k = 0, both = 0;
        logic [31:0] got_sum = '0, idle_sum = '0, cur_sum;
        logic        bsy, dn, cc, oo, idle_busy = 1'b1;
        logic        got_c = 1'b0, got_o = 1'b0;
        t_done = 0;
        drive(wide, 1'b1, s, c, av, bv);
        @(posedge clk);
        #1;
        drive(wide, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom);
        for (int k = 1; k <= w + 2; k++) begin
            @(negedge clk);
            if (inject != 0 && k == inject)
                drive(wide, 1'b1, 1'b0, 1'b0, 32'hAA, 32'h55);
            else if (inject != 0 && k == inject + 1)
                drive(wide, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            if (wide) begin
                bsy = busy16; dn = done16; cur_sum = 32'(sum16); cc = cout16; oo = ovf16;
            end else begin
                bsy = busy8; dn = done8; cur_sum = 32'(sum8); cc = cout8; oo = ovf8;
            end
            if (bsy) busy_n++;
            if (bsy && dn) both++;
            if (dn) begin
                done_n++;
                done_k  = k;
                got_sum = cur_sum; got_c = cc; got_o = oo;
                t_done  = $time;
            end
            if (k == w + 2) begin
                idle_sum  = cur_sum;
                idle_busy = bsy;
            end
        end
        chk({nm, " busy_cycles"}, busy_n, w);
        chk({nm, " done_count"}, done_n, 1);
        chk({nm, " done_cycle"}, done_k, w + 1);
        chk({nm, " busy_and_done"}, both, 0);
        chk({nm, " sum"}, got_sum, es);
        chk({nm, " cout"}, 32'(got_c), 32'(ec));
        chk({nm, " ovf"}, 32'(got_o), 32'(eo));
        chk({nm, " idle_sum_hold"}, idle_sum, es);
        chk({nm, " idle_busy"}, 32'(idle_busy), 32'd0);
    endtask

    initial begin
        time         t1, t2, tdummy;
        logic [31:0] es;
        bit          ec, eo;
        int          dn_seen;

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #3;
        chk("reset busy8", 32'(busy8), 32'd0);
        chk("reset done8", 32'(done8), 32'd0);
        chk("reset sum8", 32'(sum8), 32'd0);
        chk("reset cout8", 32'(cout8), 32'd0);
        chk("reset ovf8", 32'(ovf8), 32'd0);
        chk("reset busy16", 32'(busy16), 32'd0);
        chk("reset done16", 32'(done16), 32'd0);
        chk("reset sum16", 32'(sum16), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        add_vec(0, 0, 0, 32'h3C,   32'h0F,   32'h4B,   0, 0, 0, "add_3c_0f");
        add_vec(0, 0, 0, 32'hFF,   32'h01,   32'h00,   1, 0, 0, "add_ff_01");
        add_vec(0, 0, 0, 32'h7F,   32'h01,   32'h80,   0, 1, 0, "add_7f_01");
        add_vec(0, 1, 0, 32'h05,   32'h07,   32'hFE,   1, 0, 0, "sub_05_07");
        add_vec(0, 1, 0, 32'h80,   32'h01,   32'h7F,   0, 1, 0, "sub_80_01");
        add_vec(0, 0, 0, 32'h10,   32'h20,   32'h30,   0, 0, 3, "ignored_start");
        add_vec(1, 0, 1, 32'hFFFF, 32'h0001, 32'h0001, 1, 0, 0, "add16_ffff_1_c");
        add_vec(1, 1, 1, 32'h0000, 32'h0000, 32'hFFFF, 1, 0, 0, "sub16_0_0_b");
        add_vec(0, 1, 1, 32'h80,   32'h7F,   32'h00,   0, 1, 0, "sub_80_7f_b");
        foreach (tbl[i])
            do_op(tbl[i].wide, tbl[i].sub, tbl[i].cin, tbl[i].a, tbl[i].b, tbl[i].sum,
                  tbl[i].cout, tbl[i].ovf, tbl[i].inject, tbl[i].name, tdummy);

        do_op(1, 0, 0, 32'h1234, 32'h4321, 32'h5555, 0, 0, 0, "b2b16_first", t1);
        do_op(1, 0, 0, 32'h7FFF, 32'h0001, 32'h8000, 0, 1, 0, "b2b16_second", t2);
        chk("b2b16 spacing", 32'(t2 - t1), 32'd180);

        for (int i = 0; i < 48; i++) begin
            bit          wd = 1'($urandom_range(0, 1));
            bit          s  = 1'($urandom_range(0, 1));
            bit          c  = 1'($urandom_range(0, 1));
            logic [31:0] mk = wd ? 32'hFFFF : 32'hFF;
            logic [31:0] ra = $urandom & mk;
            logic [31:0] rb = $urandom & mk;
            model(wd ? 16 : 8, s, c, ra, rb, es, ec, eo);
            do_op(wd, s, c, ra, rb, es, ec, eo, 0, $sformatf("rand%0d", i), tdummy);
        end

        // Abort mid-RUN: outputs clear asynchronously and no done follows.
        drive(0, 1'b1, 1'b0, 1'b0, 32'hF0, 32'h33);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy8), 32'd0);
        chk("abort done", 32'(done8), 32'd0);
        chk("abort sum", 32'(sum8), 32'd0);
        chk("abort cout", 32'(cout8), 32'd0);
        chk("abort ovf", 32'(ovf8), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn_seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) dn_seen++;
        end
        chk("abort no_done", dn_seen, 0);
        do_op(0, 0, 0, 32'h01, 32'h01, 32'h02, 0, 0, 0, "post_abort", tdummy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
